// File: rtl/ast_shift.sv
// ast_shift: sliding-window extractor for Avalon-ST byte packets.
// Incoming words are appended to a byte buffer. Every output beat presents
// AST_SINK_SYMBOLS windows of up to WINDOW_SIZE bytes, one window per byte
// offset of the packet. Consuming a beat retires AST_SINK_SYMBOLS offsets by
// shifting the buffer down. The buffer is sized so that a full beat of
// windows is always available before the next word has to be accepted.
module ast_shift #(
  parameter int AST_SINK_SYMBOLS = 8,
  parameter int AST_SINK_ORDER   = 0,
  parameter int WINDOW_SIZE      = 20,
  parameter int WINDOW_SIZE_W    = (WINDOW_SIZE == 1) ? 1 : $clog2(WINDOW_SIZE),
  parameter int EMPTY_W          = (AST_SINK_SYMBOLS > 1) ? $clog2(AST_SINK_SYMBOLS) : 1
) (
  input  logic                                          clk_i,
  input  logic                                          srst_i,
  input  logic                                          en_i,

  input  logic                                          ast_sink_valid_i,
  output logic                                          ast_sink_ready_o,
  input  logic [8*AST_SINK_SYMBOLS-1:0]                 ast_sink_data_i,
  input  logic [EMPTY_W-1:0]                            ast_sink_empty_i,
  input  logic                                          ast_sink_startofpacket_i,
  input  logic                                          ast_sink_endofpacket_i,

  output logic [AST_SINK_SYMBOLS*WINDOW_SIZE*8-1:0]     windows_data_o,
  output logic [AST_SINK_SYMBOLS*(WINDOW_SIZE_W+1)-1:0] windows_data_valid_bytes_o,
  input  logic                                          windows_data_ready_i
);

  localparam int SYM   = AST_SINK_SYMBOLS;
  localparam int WIN   = WINDOW_SIZE;
  localparam int VB_W  = WINDOW_SIZE_W + 1;
  // Buffer must hold a full window behind the last lane of a beat plus one
  // more incoming word while that beat is still waiting.
  localparam int CAP   = WIN + 2*SYM - 2;
  localparam int CNT_W = $clog2(CAP + 1);

  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(WIN + SYM - 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(WIN + SYM - 2);
  localparam logic [CNT_W-1:0] SYM_C     = CNT_W'(SYM);
  localparam logic [CNT_W-1:0] WIN_C     = CNT_W'(WIN);

  // Registered state
  logic [7:0]       buf_q    [CAP];
  logic [CNT_W-1:0] cnt_q;
  logic             eop_seen_q;

  // Next-state values
  logic [7:0]       buf_next [CAP];
  logic [CNT_W-1:0] cnt_next;
  logic             eop_seen_next;

  // Helper signals
  logic [7:0]       sink_bytes [SYM];
  logic [CNT_W-1:0] word_len;
  logic [CNT_W-1:0] append_base;
  logic [CNT_W-1:0] cnt_after_consume;
  logic             accept;
  logic             beat_valid;
  logic             consume;

  // Reorder the sink word so that sink_bytes[0] is always the first packet byte.
  always_comb begin
    for (int j = 0; j < SYM; j++) begin
      if (AST_SINK_ORDER == 0) begin
        sink_bytes[j] = ast_sink_data_i[8*j +: 8];
      end else begin
        sink_bytes[j] = ast_sink_data_i[8*(SYM-1-j) +: 8];
      end
    end
  end

  // Handshake qualifiers; ready depends only on registered state and en_i.
  always_comb begin
    ast_sink_ready_o = en_i & srst_i & ~eop_seen_q & (cnt_q <= READY_MAX);
    beat_valid       = en_i & srst_i &
                       ((cnt_q >= FULL_LVL) | (eop_seen_q & (cnt_q != '0)));
    accept           = ast_sink_valid_i & ast_sink_ready_o;
    consume          = beat_valid & windows_data_ready_i;
  end

  // Work out how many bytes the current word carries and where it lands.
  // A start-of-packet word always lands at offset 0, which discards any
  // unterminated packet still sitting in the buffer.
  always_comb begin
    if (ast_sink_endofpacket_i) begin
      word_len = SYM_C - CNT_W'(ast_sink_empty_i);
    end else begin
      word_len = SYM_C;
    end

    if (ast_sink_startofpacket_i) begin
      append_base = '0;
    end else begin
      append_base = cnt_q;
    end

    if (cnt_q > SYM_C) begin
      cnt_after_consume = cnt_q - SYM_C;
    end else begin
      cnt_after_consume = '0;
    end
  end

  // Buffer next state: append on accept, shift down one beat on consume.
  always_comb begin
    buf_next = buf_q;
    if (accept) begin
      for (int j = 0; j < CAP; j++) begin
        for (int b = 0; b < SYM; b++) begin
          if (((append_base + CNT_W'(b)) == CNT_W'(j)) && (CNT_W'(b) < word_len)) begin
            buf_next[j] = sink_bytes[b];
          end
        end
      end
    end else if (consume) begin
      for (int j = 0; j < CAP - SYM; j++) begin
        buf_next[j] = buf_q[j + SYM];
      end
      for (int j = CAP - SYM; j < CAP; j++) begin
        buf_next[j] = 8'h00;
      end
    end
  end

  // Fill count and end-of-packet flag next state.
  always_comb begin
    cnt_next      = cnt_q;
    eop_seen_next = eop_seen_q;
    if (accept) begin
      cnt_next = append_base + word_len;
      if (ast_sink_endofpacket_i) begin
        eop_seen_next = 1'b1;
      end
    end else if (consume) begin
      cnt_next = cnt_after_consume;
      if (cnt_after_consume == '0) begin
        eop_seen_next = 1'b0;
      end
    end
  end

  // State registers; en_i low holds everything.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      cnt_q      <= '0;
      eop_seen_q <= 1'b0;
      for (int j = 0; j < CAP; j++) begin
        buf_q[j] <= 8'h00;
      end
    end else if (en_i) begin
      cnt_q      <= cnt_next;
      eop_seen_q <= eop_seen_next;
      for (int j = 0; j < CAP; j++) begin
        buf_q[j] <= buf_next[j];
      end
    end
  end

  // Lane i window byte k is buffer byte i+k; content beyond the length is stale.
  always_comb begin
    windows_data_o = '0;
    for (int i = 0; i < SYM; i++) begin
      for (int k = 0; k < WIN; k++) begin
        windows_data_o[(i*WIN + k)*8 +: 8] = buf_q[i + k];
      end
    end
  end

  // Lane length is min(WINDOW_SIZE, fill - lane), zero when no beat is offered.
  always_comb begin
    windows_data_valid_bytes_o = '0;
    for (int i = 0; i < SYM; i++) begin
      if (beat_valid && (cnt_q > CNT_W'(i))) begin
        if ((cnt_q - CNT_W'(i)) > WIN_C) begin
          windows_data_valid_bytes_o[i*VB_W +: VB_W] = VB_W'(WIN);
        end else begin
          windows_data_valid_bytes_o[i*VB_W +: VB_W] = VB_W'(cnt_q - CNT_W'(i));
        end
      end
    end
  end

endmodule

// File: tb/tb_ast_shift.sv
// tb_ast_shift: self-checking bench for ast_shift (8 symbols, window 20, order 0).
// A queue-of-bytes model tracks the buffered packet; every cycle the DUT
// outputs are compared against windows computed directly from that queue.
// Directed packets also carry hand-computed beat expectations.
module tb_ast_shift;

  localparam int S   = 8;
  localparam int W   = 20;
  localparam int VBW = 6;
  localparam int EW  = 3;

  logic             clk = 1'b0;
  logic             srst;
  logic             en;
  logic             sink_valid;
  logic             sink_ready;
  logic [8*S-1:0]   sink_data;
  logic [EW-1:0]    sink_empty;
  logic             sink_sop;
  logic             sink_eop;
  logic [S*W*8-1:0] win_data;
  logic [S*VBW-1:0] win_vb;
  logic             win_ready;

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 1;
  int win_cnt  = 0;

  logic [7:0]       m_q[$];
  bit               m_eop = 1'b0;
  logic [S*VBW-1:0] cap_vb[$];
  logic [S*8-1:0]   cap_b0[$];
  int               e_vb[S];
  int               e_b0[S];

  ast_shift #(
    .AST_SINK_SYMBOLS(S),
    .AST_SINK_ORDER(0),
    .WINDOW_SIZE(W)
  ) dut (
    .clk_i(clk),
    .srst_i(srst),
    .en_i(en),
    .ast_sink_valid_i(sink_valid),
    .ast_sink_ready_o(sink_ready),
    .ast_sink_data_i(sink_data),
    .ast_sink_empty_i(sink_empty),
    .ast_sink_startofpacket_i(sink_sop),
    .ast_sink_endofpacket_i(sink_eop),
    .windows_data_o(win_data),
    .windows_data_valid_bytes_o(win_vb),
    .windows_data_ready_i(win_ready)
  );

  always #5 clk = ~clk;

  // Downstream ready: held low, held high, or random.
  initial begin
    win_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       win_ready = 1'b0;
        1:       win_ready = 1'b1;
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  function automatic bit model_ready();
    return en && srst && !m_eop && (m_q.size() <= W + S - 2);
  endfunction

  function automatic bit model_valid();
    return en && srst && ((m_q.size() >= W + S - 1) || (m_eop && m_q.size() > 0));
  endfunction

  function automatic int model_len(int lane, bit v);
    if (!v || m_q.size() <= lane) return 0;
    return (m_q.size() - lane > W) ? W : m_q.size() - lane;
  endfunction

  // Per-cycle compare against the model, then advance the model by one edge.
  always @(negedge clk) begin : compare_proc
    bit               ev;
    bit               er;
    bit               bad;
    int               n;
    int               el;
    logic [S*VBW-1:0] exp_vb;
    logic [7:0]       act_b;
    ev = model_valid();
    er = model_ready();

    checks++;
    if (sink_ready !== er) begin
      failures++;
      $display("[TB] FAIL ready act=%b exp=%b t=%0t", sink_ready, er, $time);
    end

    exp_vb = '0;
    for (int i = 0; i < S; i++) exp_vb[i*VBW +: VBW] = VBW'(model_len(i, ev));
    checks++;
    if (win_vb !== exp_vb) begin
      failures++;
      bad = 1'b0;
      for (int i = 0; i < S; i++) begin
        if (!bad && win_vb[i*VBW +: VBW] !== exp_vb[i*VBW +: VBW]) begin
          bad = 1'b1;
          $display("[TB] FAIL vbytes lane=%0d act=%0d exp=%0d t=%0t",
                   i, win_vb[i*VBW +: VBW], exp_vb[i*VBW +: VBW], $time);
        end
      end
    end

    if (ev) begin
      checks++;
      bad = 1'b0;
      for (int i = 0; i < S; i++) begin
        el = model_len(i, ev);
        for (int k = 0; k < W; k++) begin
          act_b = win_data[(i*W + k)*8 +: 8];
          if (!bad && k < el && act_b !== m_q[i + k]) begin
            bad = 1'b1;
            failures++;
            $display("[TB] FAIL data lane=%0d k=%0d act=%h exp=%h t=%0t",
                     i, k, act_b, m_q[i + k], $time);
          end
        end
      end
    end

    if (ev && win_ready) begin
      cap_vb.push_back(win_vb);
      for (int i = 0; i < S; i++) begin
        act_b = win_data[(i*W)*8 +: 8];
        exp_vb[i*VBW +: VBW] = '0;
        if (win_vb[i*VBW +: VBW] != 0) win_cnt++;
      end
      cap_b0.push_back({win_data[(7*W)*8 +: 8], win_data[(6*W)*8 +: 8],
                        win_data[(5*W)*8 +: 8], win_data[(4*W)*8 +: 8],
                        win_data[(3*W)*8 +: 8], win_data[(2*W)*8 +: 8],
                        win_data[(1*W)*8 +: 8], win_data[0 +: 8]});
    end

    if (!srst) begin
      m_q.delete();
      m_eop = 1'b0;
    end else if (en) begin
      if (sink_valid && er) begin
        if (sink_sop) m_q.delete();
        n = sink_eop ? S - int'(sink_empty) : S;
        for (int j = 0; j < n; j++) m_q.push_back(sink_data[8*j +: 8]);
        if (sink_eop) m_eop = 1'b1;
      end else if (ev && win_ready) begin
        for (int j = 0; j < S; j++) if (m_q.size() > 0) void'(m_q.pop_front());
        if (m_q.size() == 0) m_eop = 1'b0;
      end
    end
  end

  task automatic send_word(input logic [8*S-1:0] d, input bit sop, input bit eop, input int emp);
    bit done;
    sink_data  = d;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_empty = EW'(emp);
    sink_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      if (sink_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #2;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL send_timeout act=not_accepted exp=accepted t=%0t", $time);
    end
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  // Packet byte p is (seed + p) mod 256; eop can be suppressed for partial packets.
  task automatic applyStimulus(input int len, input logic [7:0] seed, input bit with_eop, input bit gaps);
    int nw;
    int p;
    bit last;
    logic [8*S-1:0] d;
    nw = (len + S - 1) / S;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int b = 0; b < S; b++) begin
        p = w*S + b;
        if (p < len) d[8*b +: 8] = seed + 8'(p);
      end
      last = (w == nw - 1);
      send_word(d, w == 0, last && with_eop, last ? nw*S - len : 0);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 3000 && !idle; t++) begin
      @(posedge clk);
      #2;
      if (m_q.size() == 0 && !m_eop) idle = 1'b1;
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("[TB] FAIL flush_timeout act=busy exp=idle t=%0t", $time);
    end
  endtask

  task automatic checkOutput(input string name, input int exp_windows);
    checks++;
    if (win_cnt != exp_windows) begin
      failures++;
      $display("[TB] FAIL %s windows act=%0d exp=%0d", name, win_cnt, exp_windows);
    end
  endtask

  task automatic check_beat(input string name, input int idx);
    logic [S*VBW-1:0] v;
    logic [S*8-1:0]   b;
    bit bad;
    checks++;
    if (idx >= cap_vb.size()) begin
      failures++;
      $display("[TB] FAIL %s beat=%0d act=missing exp=present", name, idx);
    end else begin
      v = cap_vb[idx];
      b = cap_b0[idx];
      bad = 1'b0;
      for (int i = 0; i < S; i++) begin
        if (!bad && int'(v[i*VBW +: VBW]) != e_vb[i]) begin
          bad = 1'b1;
          $display("[TB] FAIL %s beat=%0d lane=%0d vbytes act=%0d exp=%0d",
                   name, idx, i, v[i*VBW +: VBW], e_vb[i]);
        end
        if (!bad && e_vb[i] > 0 && int'(b[i*8 +: 8]) != e_b0[i]) begin
          bad = 1'b1;
          $display("[TB] FAIL %s beat=%0d lane=%0d byte0 act=%h exp=%h",
                   name, idx, i, b[i*8 +: 8], e_b0[i]);
        end
      end
      if (bad) failures++;
    end
  endtask

  task automatic check_idle_outputs(input string name, input bit exp_ready);
    checks++;
    if (sink_ready !== exp_ready || win_vb !== '0) begin
      failures++;
      $display("[TB] FAIL %s act=ready:%b/vb:%h exp=ready:%b/vb:0", name, sink_ready, win_vb, exp_ready);
    end
  endtask

  task automatic check_beat_count(input string name, input int exp_n);
    checks++;
    if (cap_vb.size() != exp_n) begin
      failures++;
      $display("[TB] FAIL %s beats act=%0d exp=%0d", name, cap_vb.size(), exp_n);
    end
  endtask

  task automatic start_packet_stats();
    win_cnt = 0;
    cap_vb.delete();
    cap_b0.delete();
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog act=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fixed_len[7];
    int len;
    fixed_len = '{19, 20, 21, 26, 27, 28, 200};
    srst = 1'b0;
    en = 1'b1;
    sink_valid = 1'b0;
    sink_data = '0;
    sink_empty = '0;
    sink_sop = 1'b0;
    sink_eop = 1'b0;
    rdy_mode = 1;
    repeat (3) begin @(posedge clk); #2; end
    check_idle_outputs("reset_hold", 1'b0);
    srst = 1'b1;
    #1;
    check_idle_outputs("after_reset", 1'b1);
    #1;

    // 1-byte packet
    start_packet_stats();
    applyStimulus(1, 8'h01, 1'b1, 1'b0);
    wait_idle();
    checkOutput("pkt1", 1);
    check_beat_count("pkt1", 1);
    e_vb = '{1, 0, 0, 0, 0, 0, 0, 0};
    e_b0 = '{8'h01, 0, 0, 0, 0, 0, 0, 0};
    check_beat("pkt1", 0);

    // 8-byte packet
    start_packet_stats();
    applyStimulus(8, 8'h01, 1'b1, 1'b0);
    wait_idle();
    checkOutput("pkt8", 8);
    check_beat_count("pkt8", 1);
    e_vb = '{8, 7, 6, 5, 4, 3, 2, 1};
    e_b0 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    check_beat("pkt8", 0);

    // 30-byte packet under random downstream ready
    rdy_mode = 2;
    start_packet_stats();
    applyStimulus(30, 8'h01, 1'b1, 1'b1);
    wait_idle();
    checkOutput("pkt30", 30);
    check_beat_count("pkt30", 4);
    e_vb = '{20, 20, 20, 20, 20, 20, 20, 20};
    e_b0 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    check_beat("pkt30", 0);
    e_vb = '{20, 20, 20, 19, 18, 17, 16, 15};
    e_b0 = '{8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h10};
    check_beat("pkt30", 1);
    e_vb = '{14, 13, 12, 11, 10, 9, 8, 7};
    e_b0 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    check_beat("pkt30", 2);
    e_vb = '{6, 5, 4, 3, 2, 1, 0, 0};
    e_b0 = '{8'h19, 8'h1a, 8'h1b, 8'h1c, 8'h1d, 8'h1e, 0, 0};
    check_beat("pkt30", 3);

    // en_i low for 5 cycles with a beat pending and downstream ready high
    rdy_mode = 0;
    start_packet_stats();
    applyStimulus(30, 8'h01, 1'b1, 1'b0);
    en = 1'b0;
    rdy_mode = 1;
    repeat (5) begin
      #1;
      check_idle_outputs("en_low", 1'b0);
      @(posedge clk);
      #2;
    end
    en = 1'b1;
    #1;
    checks++;
    if (win_vb[0 +: VBW] !== VBW'(20) || win_vb[7*VBW +: VBW] !== VBW'(20) ||
        win_data[0 +: 8] !== 8'h01 || win_data[(7*W)*8 +: 8] !== 8'h08) begin
      failures++;
      $display("[TB] FAIL en_resume act=vb0:%0d/vb7:%0d/b0:%h/b7:%h exp=vb0:20/vb7:20/b0:01/b7:08",
               win_vb[0 +: VBW], win_vb[7*VBW +: VBW], win_data[0 +: 8], win_data[(7*W)*8 +: 8]);
    end
    rdy_mode = 2;
    wait_idle();
    checkOutput("en_pkt", 30);
    check_beat_count("en_pkt", 4);

    // Reset while a partial packet with a pending beat is buffered
    rdy_mode = 0;
    applyStimulus(32, 8'h50, 1'b0, 1'b0);
    srst = 1'b0;
    @(posedge clk);
    #2;
    check_idle_outputs("rst_mid", 1'b0);
    srst = 1'b1;
    #1;
    check_idle_outputs("rst_release", 1'b1);
    rdy_mode = 2;
    start_packet_stats();
    applyStimulus(45, 8'h80, 1'b1, 1'b1);
    wait_idle();
    checkOutput("post_rst", 45);

    // Unterminated packet dropped by a new start of packet
    start_packet_stats();
    applyStimulus(16, 8'h20, 1'b0, 1'b0);
    applyStimulus(37, 8'h60, 1'b1, 1'b1);
    wait_idle();
    checkOutput("sop_drop", 37);

    // Boundary lengths and random lengths with sink gaps and random ready
    for (int i = 0; i < 7; i++) begin
      start_packet_stats();
      applyStimulus(fixed_len[i], 8'(i * 13), 1'b1, 1'b1);
      wait_idle();
      checkOutput($sformatf("fixed_%0d", fixed_len[i]), fixed_len[i]);
    end
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(1, 200);
      start_packet_stats();
      applyStimulus(len, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
      wait_idle();
      checkOutput($sformatf("rand_%0d_len%0d", i, len), len);
    end

    $display("[TB] directed and random packets complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
